// File: rtl/brcomp_seq_if.sv
// brcomp_seq_if: request/response bundle for the multi-cycle branch comparator.
//   master : flush, in_valid, rs1_data, rs2_data, br_unsigned, funct3, out_ready (drives)
//            in_ready, out_valid, br_less, br_equal, br_taken, br_illegal, busy (observes)
//   slave  : the mirror image, used by brcomp_seq.
interface brcomp_seq_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             br_unsigned;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic             br_less;
  logic             br_equal;
  logic             br_taken;
  logic             br_illegal;
  logic             busy;

  modport master (
    output flush, in_valid, rs1_data, rs2_data, br_unsigned, funct3, out_ready,
    input  in_ready, out_valid, br_less, br_equal, br_taken, br_illegal, busy
  );

  modport slave (
    input  flush, in_valid, rs1_data, rs2_data, br_unsigned, funct3, out_ready,
    output in_ready, out_valid, br_less, br_equal, br_taken, br_illegal, busy
  );
endinterface

// File: rtl/brcomp_seq.sv
// brcomp_seq: multi-cycle branch comparator. Computes A - B CHUNK bits per cycle,
// LSB first, with a rippled carry and accumulated zero flag, then reports
// less/equal flags and the decoded branch-taken bit for the latched funct3.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : brcomp_seq_if.slave (request in, result out, flush, busy)
module brcomp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  brcomp_seq_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             uns_q;
  logic [2:0]       f3_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, zero_q;
  logic             less_q, equal_q, taken_q, illegal_q;

  logic             accept, last;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   sum;
  logic             eq_c, lt_c, ltu_c, taken_c, illegal_c;

  assign accept = (state_q == IDLE) && bus.in_valid && !bus.flush;
  assign last   = (cnt_q == LAST);
  assign a_ch   = a_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign b_ch   = b_q[int'(cnt_q) * CHUNK +: CHUNK];
  // A + ~B + carry: carry starts at 1 so the ripple forms A - B.
  assign sum    = {1'b0, a_ch} + {1'b0, ~b_ch} + (CHUNK+1)'(carry_q);

  // Valid only in the final RUN cycle, where sum holds the top chunk.
  assign eq_c  = zero_q & (sum[CHUNK-1:0] == '0);
  assign ltu_c = ~sum[CHUNK];
  // Differing signs: the negative operand is smaller; same signs cannot overflow.
  assign lt_c  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? a_q[WIDTH-1] : sum[CHUNK-1];

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (f3_q)
      3'b000:  taken_c = eq_c;
      3'b001:  taken_c = ~eq_c;
      3'b100:  taken_c = lt_c;
      3'b101:  taken_c = ~lt_c;
      3'b110:  taken_c = ltu_c;
      3'b111:  taken_c = ~ltu_c;
      default: illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.in_valid) state_d = RUN;
        RUN:     if (last) state_d = DONE;
        DONE:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      uns_q     <= 1'b0;
      f3_q      <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.rs1_data;
      b_q     <= bus.rs2_data;
      uns_q   <= bus.br_unsigned;
      f3_q    <= bus.funct3;
      cnt_q   <= '0;
      carry_q <= 1'b1;
      zero_q  <= 1'b1;
    end else if (state_q == RUN && !bus.flush) begin
      carry_q <= sum[CHUNK];
      zero_q  <= eq_c;
      if (last) begin
        less_q    <= uns_q ? ltu_c : lt_c;
        equal_q   <= eq_c;
        taken_q   <= taken_c;
        illegal_q <= illegal_c;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.br_less    = less_q;
  assign bus.br_equal   = equal_q;
  assign bus.br_taken   = taken_q;
  assign bus.br_illegal = illegal_q;
endmodule

// File: doc/brcomp_seq.md
# brcomp_seq

Parametrised, multi-cycle branch comparator for the branch unit. It accepts two register operands, a signedness select and the branch funct3 through a valid/ready handshake. It then subtracts the operands CHUNK bits per cycle, LSB first, using a rippled carry and an accumulated zero flag, and returns less/equal flags plus a decoded branch-taken bit. Signed less uses overflow-correct logic.

## Interface
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK cycles per compare (CHUNK = WIDTH gives N = 1).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous abort of any in-flight compare.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- rs1_data  in  WIDTH  operand A.
- rs2_data  in  WIDTH  operand B.
- br_unsigned  in  1  1 = unsigned compare for br_less.
- funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- br_less  out  1  A < B, with signedness per the latched br_unsigned.
- br_equal  out  1  A == B.
- br_taken  out  1  branch condition true for the latched funct3.
- br_illegal  out  1  latched funct3 was 010 or 011.
- busy  out  1  state is not IDLE.

## Operation
- FSM states are IDLE, RUN and DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - On in_valid && !flush, latch rs1_data, rs2_data, br_unsigned and funct3.
  - Set cnt = 0, carry = 1, zero = 1, then go to RUN.
- RUN, cycle cnt:
  - s = A[cnt*CHUNK +: CHUNK] + ~B[cnt*CHUNK +: CHUNK] + carry, computed at CHUNK+1 bits.
  - carry <= s[CHUNK]; zero <= zero & (s[CHUNK-1:0] == 0).
  - When cnt == N-1, register the results and go to DONE. Otherwise cnt <= cnt+1.
- Result equations, using the final chunk values:
  - eq = zero & (s[CHUNK-1:0] == 0).
  - ltu = ~carry_out.
  - lt = (A[W-1] ^ B[W-1]) ? A[W-1] : s[CHUNK-1]. This is the overflow-correct form; the raw difference sign alone is not sufficient.
  - br_less = br_unsigned ? ltu : lt; br_equal = eq.
- br_taken decode:
  - BEQ = eq, BNE = ~eq.
  - BLT = lt, BGE = ~lt.
  - BLTU = ltu, BGEU = ~ltu.
  - 010/011 give br_taken = 0 and br_illegal = 1.
  - br_taken ignores br_unsigned; funct3 alone selects the signedness.
- DONE:
  - Result outputs are registered and held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
  - There is no accept in the same cycle as out_ready; the next accept is possible on the following edge.
- flush, in any state, takes priority over everything else:
  - Next state is IDLE, out_valid is 0, and the in-flight result is discarded.
  - In IDLE, flush blocks the accept even when in_valid = 1.
- Reset:
  - State goes to IDLE, so in_ready = 1 as soon as rst_n deasserts.
  - out_valid, br_less, br_equal, br_taken, br_illegal, busy and cnt all reset to 0.
  - Assertion mid-RUN or mid-DONE aborts immediately; no stale result appears after release.
- Operands changing on the inputs after the accept edge have no effect on the result.

## Timing
- Accept at edge T0 (in_valid && in_ready && !flush).
- RUN occupies edges T0+1 .. T0+N; out_valid is high from just after edge T0+N. Latency is N cycles (4 at the default parameters).
- Minimum initiation interval is N+2 cycles when out_ready is held high.
- Result outputs change only on the edge entering DONE, or on reset.
- busy is high from T0 until the edge that returns the FSM to IDLE.

## Test plan
- Reset: assert rst_n = 0 mid-RUN -> all outputs 0 immediately. Release -> in_ready = 1, no out_valid pulse.
- Signed overflow: WIDTH = 32, CHUNK = 8, rs1 = 0x80000000, rs2 = 0x00000001, funct3 = 100, br_unsigned = 0 -> out_valid after 4 cycles, br_less = 1, br_equal = 0, br_taken = 1. Same operands with funct3 = 110 and br_unsigned = 1 -> br_less = 0, br_taken = 0.
- Equality across chunk boundaries:
  - rs1 = rs2 = 0xDEAD00BE, funct3 = 000 -> br_equal = 1, br_taken = 1.
  - rs1 = 0x00000100, rs2 = 0x00000000 (only chunk 1 differs) -> br_equal = 0.
- Backpressure and illegal funct3: hold out_ready = 0 for 5 cycles -> outputs stable and in_ready = 0 throughout. funct3 = 011 -> br_illegal = 1, br_taken = 0.
- Flush:
  - flush in RUN cycle 2 -> IDLE next edge, no out_valid.
  - flush together with in_valid in IDLE -> no accept.
  - A back-to-back request after the flush completes correctly.
- Parameter sweep: CHUNK = 32 (N = 1) and CHUNK = 4 (N = 8) with 1000 random operand pairs each -> flags match the reference model, with latency exactly N.
